id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS core.
- Sits between the decode stage and the EX stage.
- Drives the register addresses consumed by the forwarding unit (rs, rt, destination rd) plus the operands and control bits used by EX.
- Contains load-use hazard detection: stalls PC and IF/ID one cycle and inserts a bubble; also supports branch flush, halt freeze and a saturating bubble counter for the debug unit.

Parameters:
- NB_DATA, 32, operand/immediate width
- NB_ADDR, 5, register address width
- NB_ALUOP, 6, ALU control code width
- NB_CNT, 16, bubble counter width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_halt  in  1  freeze: every register holds, o_stall forced 0
- i_flush  in  1  branch/jump taken: squash the instruction entering EX
- i_id_valid  in  1  ID holds a real instruction
- i_rs  in  NB_ADDR  source A address from ID
- i_rt  in  NB_ADDR  source B address from ID
- i_rd  in  NB_ADDR  destination address already selected in ID (rd/rt/31)
- i_uses_rs  in  1  ID instruction reads rs
- i_uses_rt  in  1  ID instruction reads rt
- i_rs_data  in  NB_DATA  register file read A
- i_rt_data  in  NB_DATA  register file read B
- i_imm  in  NB_DATA  extended immediate
- i_alu_op  in  NB_ALUOP  ALU control
- i_alu_src  in  1  1 = B operand is immediate
- i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg  in  1 each  control bits
- o_rs, o_rt, o_rd  out  NB_ADDR each  registered addresses (to forwarding unit / EX)
- o_rs_data, o_rt_data, o_imm  out  NB_DATA each  registered operands
- o_alu_op  out  NB_ALUOP
- o_alu_src, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg  out  1 each
- o_valid  out  1  EX holds a real instruction
- o_stall  out  1  combinational: hold PC and IF/ID this cycle
- o_bubble_cnt  out  NB_CNT  bubbles inserted since reset

Behaviour:
- Reset (async, i_rst_n=0): all registered outputs 0, o_valid=0, o_bubble_cnt=0; o_stall=0 while reset is held. Deassertion takes effect at the next clock edge with no extra latency.
- Hazard (combinational):
  - o_stall = ~i_halt & i_id_valid & o_valid & o_mem_read & (o_rd != 0) & ((i_uses_rs & o_rd==i_rs) | (i_uses_rt & o_rd==i_rt)).
  - Register 0 never causes a stall.
- Per-edge priority, highest first:
  1. i_halt: all registers, including the counter, hold.
  2. i_flush: load a bubble; counter +1. Flush wins over a simultaneous stall.
  3. o_stall: load a bubble; counter +1.
  4. Otherwise, i_id_valid=1: capture all i_* fields, o_valid=1.
  5. Otherwise, i_id_valid=0: load a bubble; counter does not change.
- Bubble: o_valid, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src = 0; o_alu_op=0, o_rd=0; o_rs, o_rt, data fields = 0. The forwarding unit therefore sees rd=0 and reg_write=0.
- Latency: an ID instruction appears on the outputs 1 cycle after capture.
- A load-use stall lasts exactly 1 cycle. The bubble clears o_mem_read, so the stalled instruction is captured on the following edge.
- Back-to-back loads with a dependency each produce one bubble.
- o_bubble_cnt saturates at all-ones and never wraps.
- Reset mid-stall: outputs clear immediately; o_stall drops with o_valid.

Test Plan:
- Reset: drive random inputs with i_rst_n=0, assert asynchronously mid-cycle -> all outputs 0 immediately; after release, i_rd=5, i_reg_write=1, valid -> next edge o_rd=5, o_reg_write=1, o_valid=1.
- Load-use stall: lw rd=8 captured; next ID instr uses rs=8 (i_uses_rs=1) -> o_stall=1 that cycle; next edge bubble (o_valid=0, o_rd=0), o_stall=0, o_bubble_cnt=1; following edge the dependent instr is captured.
- No false stall: lw rd=0 with next rs=0, and lw rd=8 with next rt=8 but i_uses_rt=0 -> o_stall stays 0, no bubble.
- Flush vs stall: assert i_flush in a cycle where o_stall=1 -> bubble, counter +1 (not +2), o_valid=0.
- Halt: load instr (rd=3, rs_data=0xDEADBEEF), assert i_halt for 4 cycles with a hazard present -> outputs unchanged, o_stall=0, counter unchanged; release -> stall resumes.
- Counter saturation: NB_CNT=4, force 20 flushes -> o_bubble_cnt stops at 15.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch flush,
// halt freeze and a saturating count of inserted bubbles.
module id_ex_reg #(
  parameter int NB_DATA  = 32,
  parameter int NB_ADDR  = 5,
  parameter int NB_ALUOP = 6,
  parameter int NB_CNT   = 16
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_halt,
  input  logic                i_flush,
  input  logic                i_id_valid,
  input  logic [NB_ADDR-1:0]  i_rs,
  input  logic [NB_ADDR-1:0]  i_rt,
  input  logic [NB_ADDR-1:0]  i_rd,
  input  logic                i_uses_rs,
  input  logic                i_uses_rt,
  input  logic [NB_DATA-1:0]  i_rs_data,
  input  logic [NB_DATA-1:0]  i_rt_data,
  input  logic [NB_DATA-1:0]  i_imm,
  input  logic [NB_ALUOP-1:0] i_alu_op,
  input  logic                i_alu_src,
  input  logic                i_reg_write,
  input  logic                i_mem_read,
  input  logic                i_mem_write,
  input  logic                i_mem_to_reg,
  output logic [NB_ADDR-1:0]  o_rs,
  output logic [NB_ADDR-1:0]  o_rt,
  output logic [NB_ADDR-1:0]  o_rd,
  output logic [NB_DATA-1:0]  o_rs_data,
  output logic [NB_DATA-1:0]  o_rt_data,
  output logic [NB_DATA-1:0]  o_imm,
  output logic [NB_ALUOP-1:0] o_alu_op,
  output logic                o_alu_src,
  output logic                o_reg_write,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_mem_to_reg,
  output logic                o_valid,
  output logic                o_stall,
  output logic [NB_CNT-1:0]   o_bubble_cnt
);

  function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
    return (&v) ? v : v + {{(NB_CNT-1){1'b0}}, 1'b1};
  endfunction

  logic [NB_ADDR-1:0]  r_rs, r_rt, r_rd;
  logic [NB_DATA-1:0]  r_rs_data, r_rt_data, r_imm;
  logic [NB_ALUOP-1:0] r_alu_op;
  logic                r_alu_src, r_reg_write, r_mem_read, r_mem_write, r_mem_to_reg;
  logic                r_valid;
  logic [NB_CNT-1:0]   r_bubble_cnt;

  logic w_rs_hit, w_rt_hit, w_stall, w_bubble_cnt_inc, w_load;

  // A load in EX whose destination is read by the ID instruction must wait.
  assign w_rs_hit = i_uses_rs & (r_rd == i_rs);
  assign w_rt_hit = i_uses_rt & (r_rd == i_rt);
  assign w_stall  = ~i_halt & i_id_valid & r_valid & r_mem_read &
                    (r_rd != '0) & (w_rs_hit | w_rt_hit);

  assign w_bubble_cnt_inc = i_flush | w_stall;
  assign w_load           = i_id_valid & ~w_bubble_cnt_inc;

  // ID -> EX boundary: every field either captures ID or clears to a bubble.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_alu_op     <= '0;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_valid      <= 1'b0;
      r_bubble_cnt <= '0;
    end else if (!i_halt) begin
      r_rs         <= w_load ? i_rs         : '0;
      r_rt         <= w_load ? i_rt         : '0;
      r_rd         <= w_load ? i_rd         : '0;
      r_rs_data    <= w_load ? i_rs_data    : '0;
      r_rt_data    <= w_load ? i_rt_data    : '0;
      r_imm        <= w_load ? i_imm        : '0;
      r_alu_op     <= w_load ? i_alu_op     : '0;
      r_alu_src    <= w_load & i_alu_src;
      r_reg_write  <= w_load & i_reg_write;
      r_mem_read   <= w_load & i_mem_read;
      r_mem_write  <= w_load & i_mem_write;
      r_mem_to_reg <= w_load & i_mem_to_reg;
      r_valid      <= w_load;
      if (w_bubble_cnt_inc)
        r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end
  end

  assign o_rs         = r_rs;
  assign o_rt         = r_rt;
  assign o_rd         = r_rd;
  assign o_rs_data    = r_rs_data;
  assign o_rt_data    = r_rt_data;
  assign o_imm        = r_imm;
  assign o_alu_op     = r_alu_op;
  assign o_alu_src    = r_alu_src;
  assign o_reg_write  = r_reg_write;
  assign o_mem_read   = r_mem_read;
  assign o_mem_write  = r_mem_write;
  assign o_mem_to_reg = r_mem_to_reg;
  assign o_valid      = r_valid;
  assign o_stall      = w_stall;
  assign o_bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed-vector bench for id_ex_reg; counter width reduced to 4 bits so
// saturation is reachable in a few cycles.
module tb_id_ex_reg;
  localparam int NB_DATA = 32, NB_ADDR = 5, NB_ALUOP = 6, NB_CNT = 4;

  logic clk = 1'b0;
  logic i_rst_n, i_halt, i_flush, i_id_valid;
  logic [NB_ADDR-1:0] i_rs, i_rt, i_rd;
  logic i_uses_rs, i_uses_rt;
  logic [NB_DATA-1:0] i_rs_data, i_rt_data, i_imm;
  logic [NB_ALUOP-1:0] i_alu_op;
  logic i_alu_src, i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg;
  logic [NB_ADDR-1:0] o_rs, o_rt, o_rd;
  logic [NB_DATA-1:0] o_rs_data, o_rt_data, o_imm;
  logic [NB_ALUOP-1:0] o_alu_op;
  logic o_alu_src, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg;
  logic o_valid, o_stall;
  logic [NB_CNT-1:0] o_bubble_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [NB_CNT-1:0] exp_cnt;

  id_ex_reg #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_ALUOP(NB_ALUOP), .NB_CNT(NB_CNT)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_halt(i_halt), .i_flush(i_flush), .i_id_valid(i_id_valid),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_uses_rs(i_uses_rs), .i_uses_rt(i_uses_rt),
    .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm), .i_alu_op(i_alu_op),
    .i_alu_src(i_alu_src), .i_reg_write(i_reg_write), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_mem_to_reg(i_mem_to_reg),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
    .o_imm(o_imm), .o_alu_op(o_alu_op), .o_alu_src(o_alu_src), .o_reg_write(o_reg_write),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg),
    .o_valid(o_valid), .o_stall(o_stall), .o_bubble_cnt(o_bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_halt = 0; i_flush = 0; i_id_valid = 0;
    i_rs = 0; i_rt = 0; i_rd = 0; i_uses_rs = 0; i_uses_rt = 0;
    i_rs_data = 0; i_rt_data = 0; i_imm = 0; i_alu_op = 0;
    i_alu_src = 0; i_reg_write = 0; i_mem_read = 0; i_mem_write = 0; i_mem_to_reg = 0;
  endtask

  task automatic drive_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic urs, input logic urt, input logic mrd,
                             input logic [31:0] rs_data);
    clear_inputs();
    i_id_valid = 1; i_rs = rs; i_rt = rt; i_rd = rd;
    i_uses_rs = urs; i_uses_rt = urt; i_mem_read = mrd; i_mem_to_reg = mrd;
    i_reg_write = 1; i_rs_data = rs_data;
  endtask

  task automatic test_reset();
    i_rst_n = 0;
    clear_inputs();
    i_id_valid = 1; i_rs = 5'($urandom); i_rt = 5'($urandom); i_rd = 5'($urandom);
    i_rs_data = $urandom; i_rt_data = $urandom; i_imm = $urandom; i_alu_op = 6'($urandom);
    i_reg_write = 1; i_mem_read = 1; i_uses_rs = 1;
    tick(); tick();
    n_checks++;
    if (o_valid !== 0 || o_rd !== 0 || o_rs_data !== 0 || o_bubble_cnt !== 0 || o_stall !== 0) begin
      n_fail++; $display("FAIL reset_hold: valid=%0b rd=%0d rs_data=%h cnt=%0d stall=%0b, want all 0",
                         o_valid, o_rd, o_rs_data, o_bubble_cnt, o_stall);
    end
    i_rst_n = 1;
    tick();
    n_checks++;
    if (o_valid !== 1) begin n_fail++; $display("FAIL reset_release_capture: valid=%0b want 1", o_valid); end
    #3 i_rst_n = 0;
    #1;
    n_checks++;
    if (o_valid !== 0 || o_rd !== 0 || o_rs !== 0 || o_rt_data !== 0 || o_imm !== 0 ||
        o_alu_op !== 0 || o_reg_write !== 0 || o_mem_read !== 0 || o_stall !== 0) begin
      n_fail++; $display("FAIL reset_async: valid=%0b rd=%0d imm=%h alu_op=%0d rw=%0b mr=%0b stall=%0b, want 0",
                         o_valid, o_rd, o_imm, o_alu_op, o_reg_write, o_mem_read, o_stall);
    end
    exp_cnt = 0;
    clear_inputs();
    i_id_valid = 1; i_rd = 5; i_reg_write = 1; i_alu_op = 6'h21; i_imm = 32'hFFFF_FFF0;
    i_alu_src = 1; i_mem_write = 1;
    #1 i_rst_n = 1;
    tick();
    n_checks++;
    if (o_rd !== 5 || o_reg_write !== 1 || o_valid !== 1 || o_alu_op !== 6'h21 ||
        o_imm !== 32'hFFFF_FFF0 || o_alu_src !== 1 || o_mem_write !== 1) begin
      n_fail++; $display("FAIL first_capture: rd=%0d rw=%0b valid=%0b alu_op=%h imm=%h, want 5 1 1 21 fffffff0",
                         o_rd, o_reg_write, o_valid, o_alu_op, o_imm);
    end
  endtask

  task automatic test_load_use();
    drive_instr(1, 2, 8, 1, 0, 1, 32'h0);
    #1;
    n_checks++;
    if (o_stall !== 0) begin n_fail++; $display("FAIL lu_no_stall_before: stall=%0b want 0", o_stall); end
    tick();
    drive_instr(8, 3, 9, 1, 0, 0, 32'h1234);
    #1;
    n_checks++;
    if (o_stall !== 1) begin n_fail++; $display("FAIL lu_stall: stall=%0b want 1", o_stall); end
    tick();
    exp_cnt = exp_cnt + 1;
    n_checks++;
    if (o_valid !== 0 || o_rd !== 0 || o_stall !== 0 || o_bubble_cnt !== exp_cnt || o_mem_read !== 0) begin
      n_fail++; $display("FAIL lu_bubble: valid=%0b rd=%0d stall=%0b cnt=%0d mr=%0b, want 0 0 0 %0d 0",
                         o_valid, o_rd, o_stall, o_bubble_cnt, o_mem_read, exp_cnt);
    end
    tick();
    n_checks++;
    if (o_valid !== 1 || o_rd !== 9 || o_rs !== 8 || o_rs_data !== 32'h1234) begin
      n_fail++; $display("FAIL lu_dependent_capture: valid=%0b rd=%0d rs=%0d rs_data=%h, want 1 9 8 1234",
                         o_valid, o_rd, o_rs, o_rs_data);
    end
  endtask

  task automatic test_no_false_stall();
    drive_instr(1, 2, 0, 1, 0, 1, 32'h0);
    tick();
    drive_instr(0, 4, 6, 1, 0, 0, 32'h0);
    #1;
    n_checks++;
    if (o_stall !== 0) begin n_fail++; $display("FAIL nfs_reg0: stall=%0b want 0", o_stall); end
    tick();
    drive_instr(1, 2, 8, 1, 0, 1, 32'h0);
    tick();
    drive_instr(2, 8, 7, 1, 0, 0, 32'h55);
    #1;
    n_checks++;
    if (o_stall !== 0) begin n_fail++; $display("FAIL nfs_rt_unused: stall=%0b want 0", o_stall); end
    tick();
    n_checks++;
    if (o_valid !== 1 || o_rt !== 8 || o_rd !== 7 || o_bubble_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL nfs_captured: valid=%0b rt=%0d rd=%0d cnt=%0d, want 1 8 7 %0d",
                         o_valid, o_rt, o_rd, o_bubble_cnt, exp_cnt);
    end
    clear_inputs();
    tick();
    n_checks++;
    if (o_valid !== 0 || o_rd !== 0 || o_bubble_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL idle_bubble: valid=%0b rd=%0d cnt=%0d, want 0 0 %0d",
                         o_valid, o_rd, o_bubble_cnt, exp_cnt);
    end
  endtask

  task automatic test_flush_vs_stall();
    drive_instr(1, 2, 8, 1, 0, 1, 32'h0);
    tick();
    drive_instr(8, 3, 9, 1, 0, 0, 32'h0);
    i_flush = 1;
    #1;
    n_checks++;
    if (o_stall !== 1) begin n_fail++; $display("FAIL fvs_stall: stall=%0b want 1", o_stall); end
    tick();
    exp_cnt = exp_cnt + 1;
    n_checks++;
    if (o_valid !== 0 || o_bubble_cnt !== exp_cnt || o_rd !== 0) begin
      n_fail++; $display("FAIL fvs_bubble: valid=%0b cnt=%0d rd=%0d, want 0 %0d 0",
                         o_valid, o_bubble_cnt, o_rd, exp_cnt);
    end
    i_flush = 0;
  endtask

  task automatic test_halt();
    drive_instr(4, 5, 3, 1, 0, 1, 32'hDEADBEEF);
    tick();
    drive_instr(3, 6, 10, 1, 0, 0, 32'h0);
    i_halt = 1;
    #1;
    n_checks++;
    if (o_stall !== 0) begin n_fail++; $display("FAIL halt_stall: stall=%0b want 0", o_stall); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (o_rd !== 3 || o_rs_data !== 32'hDEADBEEF || o_valid !== 1 || o_mem_read !== 1 ||
          o_stall !== 0 || o_bubble_cnt !== exp_cnt) begin
        n_fail++; $display("FAIL halt_hold[%0d]: rd=%0d rs_data=%h valid=%0b stall=%0b cnt=%0d, want 3 deadbeef 1 0 %0d",
                           k, o_rd, o_rs_data, o_valid, o_stall, o_bubble_cnt, exp_cnt);
      end
    end
    i_halt = 0;
    #1;
    n_checks++;
    if (o_stall !== 1) begin n_fail++; $display("FAIL halt_release_stall: stall=%0b want 1", o_stall); end
    tick();
    exp_cnt = exp_cnt + 1;
    n_checks++;
    if (o_valid !== 0 || o_bubble_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL halt_release_bubble: valid=%0b cnt=%0d, want 0 %0d", o_valid, o_bubble_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    drive_instr(1, 2, 10, 1, 0, 1, 32'h0);
    tick();
    drive_instr(10, 2, 11, 1, 0, 1, 32'h0);
    #1;
    n_checks++;
    if (o_stall !== 1) begin n_fail++; $display("FAIL b2b_stall1: stall=%0b want 1", o_stall); end
    tick();
    exp_cnt = exp_cnt + 1;
    tick();
    n_checks++;
    if (o_valid !== 1 || o_rd !== 11 || o_mem_read !== 1 || o_bubble_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL b2b_load2: valid=%0b rd=%0d mr=%0b cnt=%0d, want 1 11 1 %0d",
                         o_valid, o_rd, o_mem_read, o_bubble_cnt, exp_cnt);
    end
    drive_instr(7, 11, 12, 0, 1, 0, 32'h0);
    #1;
    n_checks++;
    if (o_stall !== 1) begin n_fail++; $display("FAIL b2b_stall2: stall=%0b want 1", o_stall); end
    tick();
    exp_cnt = exp_cnt + 1;
    tick();
    n_checks++;
    if (o_valid !== 1 || o_rd !== 12 || o_rt !== 11 || o_bubble_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL b2b_use: valid=%0b rd=%0d rt=%0d cnt=%0d, want 1 12 11 %0d",
                         o_valid, o_rd, o_rt, o_bubble_cnt, exp_cnt);
    end
  endtask

  task automatic test_saturation();
    clear_inputs();
    i_flush = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 1;
    end
    n_checks++;
    if (o_bubble_cnt !== 4'hF || exp_cnt !== 4'hF || o_valid !== 0) begin
      n_fail++; $display("FAIL sat_count: cnt=%0d valid=%0b, want 15 0", o_bubble_cnt, o_valid);
    end
    i_flush = 0;
  endtask

  initial begin
    exp_cnt = 0;
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_flush_vs_stall();
    test_halt();
    test_back_to_back();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
